// File: rtl/layer0_input_packer_pkg.sv
// Shared types and constants for the layer-0 input packer: FSM states,
// per-feature code width and the fill-buffer index width helper.
package layer0_input_packer_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int FEAT_W = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer0_input_packer_input_quantizer.sv
// Two-bit thermometer-count quantizer: code = number of thresholds that are
// less than or equal to the signed sample.
module input_quantizer #(
  parameter int IN_WIDTH = 16,
  parameter int THR1     = 64,
  parameter int THR2     = 128,
  parameter int THR3     = 192
) (
  input  logic signed [IN_WIDTH-1:0] data,
  output logic        [1:0]          code
);

  localparam logic signed [IN_WIDTH-1:0] T1 = IN_WIDTH'(THR1);
  localparam logic signed [IN_WIDTH-1:0] T2 = IN_WIDTH'(THR2);
  localparam logic signed [IN_WIDTH-1:0] T3 = IN_WIDTH'(THR3);

  logic ge1, ge2, ge3;

  always_comb begin
    ge1  = (data >= T1);
    ge2  = (data >= T2);
    ge3  = (data >= T3);
    code = {1'b0, ge1} + {1'b0, ge2} + {1'b0, ge3};
  end

endmodule

// File: rtl/layer0_input_packer.sv
// Collects one frame of quantized features into a fill buffer and presents
// the packed vector on a single-entry valid/ready output slot.
module layer0_input_packer
  import layer0_input_packer_pkg::*;
#(
  parameter int NUM_FEATURES = 48,
  parameter int IN_WIDTH     = 16,
  parameter int THR1         = 64,
  parameter int THR2         = 128,
  parameter int THR3         = 192
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [IN_WIDTH-1:0]          s_data,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [FEAT_W*NUM_FEATURES-1:0] m_data,
  output logic                         err_frame
);

  localparam int IDX_W = idx_width(NUM_FEATURES);
  localparam int VEC_W = FEAT_W * NUM_FEATURES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  generate
    if (!((THR1 < THR2) && (THR2 < THR3))) begin : g_bad_thresholds
      $error("layer0_input_packer: thresholds must satisfy THR1 < THR2 < THR3");
    end
  endgenerate

  // Handshakes: a beat moves on either side only in a cycle where that
  // side's valid and ready are both 1; m_data is frozen while m_valid=1.
  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [VEC_W-1:0] fill_buf;
  logic [VEC_W-1:0] next_buf;
  logic             drain_pending;
  logic [1:0]       q;
  logic             accept;
  logic             out_free;

  input_quantizer #(
    .IN_WIDTH (IN_WIDTH),
    .THR1     (THR1),
    .THR2     (THR2),
    .THR3     (THR3)
  ) u_quant (
    .data (s_data),
    .code (q)
  );

  assign s_ready  = (state != ST_HOLD);
  assign accept   = s_valid && s_ready;
  assign out_free = !m_valid || m_ready;

  // Buffer as it looks with the current beat's code merged in, so the final
  // beat of a frame can be forwarded without an extra cycle.
  always_comb begin
    next_buf = fill_buf;
    next_buf[int'(idx)*FEAT_W +: FEAT_W] = q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_FILL;
      idx           <= '0;
      fill_buf      <= '0;
      drain_pending <= 1'b0;
      m_valid       <= 1'b0;
      m_data        <= '0;
      err_frame     <= 1'b0;
    end else begin
      err_frame <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      case (state)
        ST_FILL: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              fill_buf  <= next_buf;
              idx       <= '0;
              err_frame <= !s_last;
              if (out_free) begin
                m_data  <= next_buf;
                m_valid <= 1'b1;
                state   <= s_last ? ST_FILL : ST_DRAIN;
              end else begin
                state         <= ST_HOLD;
                drain_pending <= !s_last;
              end
            end else if (s_last) begin
              fill_buf  <= '0;
              idx       <= '0;
              err_frame <= 1'b1;
            end else begin
              fill_buf <= next_buf;
              idx      <= idx + IDX_W'(1);
            end
          end
        end
        ST_HOLD: begin
          // m_valid is necessarily 1 here; refill the slot as it empties.
          if (m_ready) begin
            m_data        <= fill_buf;
            m_valid       <= 1'b1;
            state         <= drain_pending ? ST_DRAIN : ST_FILL;
            drain_pending <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (accept && s_last) state <= ST_FILL;
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_layer0_input_packer.sv
// Directed bench for layer0_input_packer with four features per frame.
module tb_layer0_input_packer;

  localparam int NF = 4;
  localparam int IW = 16;

  logic            clk;
  logic            rst_n;
  logic            s_valid;
  logic            s_ready;
  logic [IW-1:0]   s_data;
  logic            s_last;
  logic            m_valid;
  logic            m_ready;
  logic [2*NF-1:0] m_data;
  logic            err_frame;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [2*NF-1:0] exp_q[$];
  logic            mon_en = 1'b0;
  int              n_seen = 0;
  int              last_cyc = -1;
  int              vals[4] = '{-5, 64, 150, 300};

  layer0_input_packer #(
    .NUM_FEATURES (NF),
    .IN_WIDTH     (IW),
    .THR1         (64),
    .THR2         (128),
    .THR3         (192)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .err_frame (err_frame)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one beat, inputs change 1 time unit after the rising edge
  task automatic beat(input int d, input bit last);
    chk("s_ready_before_beat", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = IW'(d);
    s_last  = last;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic frame4(input int d0, input int d1, input int d2, input int d3, input bit last);
    beat(d0, 1'b0);
    beat(d1, 1'b0);
    beat(d2, 1'b0);
    beat(d3, last);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // scoreboard for the streaming section
  always @(negedge clk) begin
    if (mon_en && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_output", 32'(m_data), 32'hFFFF_FFFF);
      end else begin
        chk("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      if (last_cyc >= 0) chk("sb_spacing", 32'(cyc - last_cyc), 32'd4);
      last_cyc = cyc;
      n_seen++;
    end
  end

  initial begin
    logic [2*NF-1:0] e;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_err", 32'(err_frame), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // quantizer: -5,64,150,300 -> codes 0,1,2,3
    m_ready = 1'b1;
    beat(-5, 1'b0);
    beat(64, 1'b0);
    beat(150, 1'b0);
    chk("q_no_early_valid", 32'(m_valid), 32'd0);
    beat(300, 1'b1);
    chk("q_m_valid", 32'(m_valid), 32'd1);
    chk("q_m_data", 32'(m_data), 32'hE4);
    chk("q_err", 32'(err_frame), 32'd0);
    tick();
    chk("q_consumed", 32'(m_valid), 32'd0);

    // backpressure: two frames with m_ready low
    m_ready = 1'b0;
    frame4(300, 300, 300, 300, 1'b1);
    chk("bp_f1_valid", 32'(m_valid), 32'd1);
    chk("bp_f1_data", 32'(m_data), 32'hFF);
    frame4(64, 128, 192, -1, 1'b1);
    chk("bp_hold_s_ready", 32'(s_ready), 32'd0);
    chk("bp_hold_data", 32'(m_data), 32'hFF);
    s_valid = 1'b1;
    s_data  = IW'(-100);
    tick();
    tick();
    s_valid = 1'b0;
    chk("bp_hold_stable", 32'(m_data), 32'hFF);
    chk("bp_hold_still", 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("bp_f2_valid", 32'(m_valid), 32'd1);
    chk("bp_f2_data", 32'(m_data), 32'h39);
    chk("bp_s_ready_back", 32'(s_ready), 32'd1);
    m_ready = 1'b1;
    tick();
    chk("bp_drained", 32'(m_valid), 32'd0);

    // early last after two beats
    beat(300, 1'b0);
    beat(300, 1'b1);
    chk("el_err", 32'(err_frame), 32'd1);
    chk("el_no_valid", 32'(m_valid), 32'd0);
    tick();
    chk("el_err_pulse", 32'(err_frame), 32'd0);
    chk("el_no_valid2", 32'(m_valid), 32'd0);
    frame4(-5, 64, 150, 300, 1'b1);
    chk("el_next_valid", 32'(m_valid), 32'd1);
    chk("el_next_data", 32'(m_data), 32'hE4);
    tick();

    // missing last: six beats, last only on beat six
    frame4(150, 150, 150, 150, 1'b0);
    chk("ml_valid", 32'(m_valid), 32'd1);
    chk("ml_data", 32'(m_data), 32'hAA);
    chk("ml_err", 32'(err_frame), 32'd1);
    beat(300, 1'b0);
    chk("ml_err_once", 32'(err_frame), 32'd0);
    chk("ml_discard5", 32'(m_valid), 32'd0);
    beat(300, 1'b1);
    chk("ml_discard6", 32'(m_valid), 32'd0);
    chk("ml_err_none", 32'(err_frame), 32'd0);
    frame4(64, 64, 64, 64, 1'b1);
    chk("ml_next_valid", 32'(m_valid), 32'd1);
    chk("ml_next_data", 32'(m_data), 32'h55);
    tick();

    // missing last on a blocked frame: HOLD first, then DRAIN
    m_ready = 1'b0;
    frame4(-5, -5, -5, -5, 1'b1);
    chk("bml_f1_data", 32'(m_data), 32'h00);
    frame4(300, 300, 300, 300, 1'b0);
    chk("bml_hold", 32'(s_ready), 32'd0);
    chk("bml_err", 32'(err_frame), 32'd1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("bml_f2_data", 32'(m_data), 32'hFF);
    chk("bml_drain_ready", 32'(s_ready), 32'd1);
    beat(300, 1'b1);
    chk("bml_discard_data", 32'(m_data), 32'hFF);
    chk("bml_discard_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    tick();
    chk("bml_drained", 32'(m_valid), 32'd0);
    frame4(-5, 64, 150, 300, 1'b1);
    chk("bml_next_data", 32'(m_data), 32'hE4);
    tick();

    // reset while in HOLD
    m_ready = 1'b0;
    frame4(300, 300, 300, 300, 1'b1);
    frame4(64, 128, 192, -1, 1'b1);
    chk("rh_hold", 32'(s_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rh_m_valid", 32'(m_valid), 32'd0);
    chk("rh_s_ready", 32'(s_ready), 32'd1);
    chk("rh_m_data", 32'(m_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rh_m_valid_held", 32'(m_valid), 32'd0);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rh_no_stale", 32'(m_valid), 32'd0);
      chk("rh_no_err", 32'(err_frame), 32'd0);
    end

    // throughput: ten back-to-back frames
    mon_en = 1'b1;
    for (int f = 0; f < 10; f++) begin
      e = '0;
      for (int b = 0; b < NF; b++) e[2*b +: 2] = 2'((f + b) % 4);
      exp_q.push_back(e);
    end
    for (int f = 0; f < 10; f++) begin
      for (int b = 0; b < NF; b++) beat(vals[(f + b) % 4], b == NF - 1);
    end
    repeat (3) tick();
    mon_en = 1'b0;
    chk("tp_count", 32'(n_seen), 32'd10);
    chk("tp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer0_input_packer.md
LAYER0_INPUT_PACKER -- requirements
Module: layer0_input_packer

Interface
REQ-001 Parameter NUM_FEATURES, default 48, sets the number of input features per frame.
REQ-002 Parameter IN_WIDTH, default 16, sets the signed raw sample width.
REQ-003 Parameter THR1, THR2, THR3, defaults 64, 128, 192; these signed quantizer thresholds SHALL satisfy THR1<THR2<THR3 (elaboration-time check).
REQ-004 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port s_valid, input, 1 bit: raw sample valid.
REQ-007 Port s_ready, output, 1 bit: block accepts a sample.
REQ-008 Port s_data, input, IN_WIDTH bits: signed raw feature sample, in feature order 0..NUM_FEATURES-1.
REQ-009 Port s_last, input, 1 bit: marks the final sample of a frame.
REQ-010 Port m_valid, output, 1 bit: packed vector valid toward the layer-0 neuron LUTs.
REQ-011 Port m_ready, input, 1 bit: consumer accepts the vector.
REQ-012 Port m_data, output, 2*NUM_FEATURES bits: feature i occupies bits [2i+1:2i].
REQ-013 Port err_frame, output, 1 bit: one-cycle pulse on a frame length error.

Function
REQ-014 A beat SHALL transfer on the input side only when s_valid and s_ready are both 1; the same rule applies on the output side with m_valid and m_ready.
REQ-015 The quantized code q of each accepted sample SHALL be the unsigned 2-bit count of thresholds with THRk <= s_data, using a signed compare, so q is in 0..3.
REQ-016 q SHALL be written into the fill buffer at slot idx, where idx is a counter of width clog2(NUM_FEATURES) that resets to 0.
REQ-017 The FSM SHALL have exactly three states: FILL, HOLD and DRAIN; the reset state is FILL.
REQ-018 In FILL, s_ready SHALL be 1, and each accepted beat with idx<NUM_FEATURES-1 and s_last=0 SHALL increment idx.
REQ-019 In FILL, an accepted beat with idx==NUM_FEATURES-1 SHALL complete the frame and set idx to 0.
REQ-020 On frame completion, if the output slot is empty or is being consumed in the same cycle, the fill buffer SHALL be copied to m_data, m_valid SHALL be 1 the next cycle, and the FSM SHALL stay in FILL.
REQ-021 On frame completion with the output slot occupied and not consumed, the FSM SHALL go to HOLD.
REQ-022 In HOLD, s_ready SHALL be 0; the FSM SHALL transfer the buffer and return to FILL in the cycle the output is consumed.
REQ-023 Latency from the final input beat to m_valid SHALL be 1 cycle when the output slot is free.
REQ-024 A completing beat with s_last=0 SHALL still emit the frame, pulse err_frame, and enter DRAIN; if that frame was also blocked, DRAIN SHALL take precedence only after the HOLD transfer completes.
REQ-025 In DRAIN, s_ready SHALL be 1 and beats SHALL be discarded; the beat with s_last=1 SHALL return the FSM to FILL.
REQ-026 An accepted s_last=1 beat with idx<NUM_FEATURES-1 (early last) SHALL discard the partial frame, pulse err_frame, and set idx to 0 with no m_valid produced.
REQ-027 m_valid SHALL stay at 1 and m_data SHALL stay stable until consumed; m_data SHALL never change while m_valid=1 and m_ready=0.
REQ-028 Simultaneous output consumption and frame completion SHALL give back-to-back m_valid with no bubble.
REQ-029 Sustained throughput SHALL be 1 sample per cycle when m_ready=1.

Reset
REQ-030 While rst_n=0, the block SHALL hold FSM=FILL, idx=0, m_valid=0, m_data=0, err_frame=0, fill buffer=0, and s_ready=1.
REQ-031 Reset asserted mid-frame or during HOLD SHALL drop all partial and pending data with no err_frame pulse.
REQ-032 Reset deassertion SHALL take effect on the first clk edge after rst_n rises; no transfer SHALL be accepted in that cycle.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the feature bit width constant (2), and a function returning the buffer index width.
REQ-034 The quantizer SHALL be one combinational sub-module named input_quantizer, with IN_WIDTH and THR1..THR3 as parameters.
REQ-035 No other sub-modules SHALL be used; the fill buffer and output register are flat registers.

Verification
REQ-036 Quantizer check: with NUM_FEATURES=4, drive samples -5, 64, 150, 300 (last on beat 4), m_ready=1 -> m_data=8'b11_10_01_00, m_valid one cycle after beat 4.
REQ-037 Backpressure check: hold m_ready=0, send two full frames -> s_ready=0 after the second frame's last beat (HOLD); m_ready=1 for 1 cycle -> frame 2 appears next cycle and s_ready returns to 1.
REQ-038 Early-last check: NUM_FEATURES=4, 2 beats with s_last on beat 2 -> err_frame pulses 1 cycle, no m_valid; the next 4-beat frame packs correctly.
REQ-039 Missing-last check: 6 beats with s_last only on beat 6 -> frame of beats 1-4 emitted, err_frame pulses once, beats 5-6 discarded.
REQ-040 Mid-operation reset check: assert rst_n=0 in HOLD -> m_valid=0 and s_ready=1 while in reset, and no stale frame appears after release.
REQ-041 Throughput check: stream 10 frames at m_ready=1 -> 10 m_valid beats, each 4 cycles apart, with no data loss.
